// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file (rf_mp) and its scoreboard.
package rf_pkg;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);

  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_e;

  typedef struct packed {
    logic             en;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_port_t;

  typedef struct packed {
    logic             en;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_rd_port_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, write clears, set wins, flush zeroes all.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREG = RF_NREG,
  parameter  int NRP  = 2,
  parameter  int NWP  = 2,
  localparam int AW   = $clog2(NREG)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NWP-1:0]          clr_en,
  input  logic [NWP-1:0][AW-1:0]  clr_addr,
  input  logic                    set_en,
  input  logic [AW-1:0]           set_addr,
  input  logic [NRP-1:0][AW-1:0]  lk_addr,
  output logic [NRP-1:0]          busy
);
  logic [NREG-1:0] pend, pend_nxt;

  always_comb begin
    pend_nxt = pend;
    if (flush) pend_nxt = '0;
    else begin
      for (int w = 0; w < NWP; w++)
        if (clr_en[w]) pend_nxt[clr_addr[w]] = 1'b0;
      if (set_en) pend_nxt[set_addr] = 1'b1;
    end
    // x0 can never be pending
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;

  always_comb
    for (int i = 0; i < NRP; i++) busy[i] = pend[lk_addr[i]];
endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with x0 hardwired to zero, pending scoreboard and clear sweep.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module rf_mp
  import rf_pkg::*;
#(
  parameter  int DW   = RF_DW,
  parameter  int NREG = RF_NREG,
  parameter  int NRP  = 2,
  parameter  int NWP  = 2,
  localparam int AW   = $clog2(NREG)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    ready,
  input  logic [NWP-1:0]          wr_en,
  input  logic [NWP-1:0][AW-1:0]  wr_addr,
  input  logic [NWP-1:0][DW-1:0]  wr_data,
  input  logic [NRP-1:0][AW-1:0]  rd_addr,
  output logic [NRP-1:0][DW-1:0]  rd_data,
  input  logic                    sb_set_en,
  input  logic [AW-1:0]           sb_set_addr,
  output logic [NRP-1:0]          sb_busy
);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  rf_state_e       state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic            idle;
  logic [NWP-1:0]  wr_ok;
  logic [NRP-1:0]  busy_raw;
  logic [DW-1:0]   regs [1:NREG-1];

  assign idle  = (state == RF_IDLE);
  assign ready = idle;

  always_comb
    for (int w = 0; w < NWP; w++) wr_ok[w] = idle && wr_en[w] && (wr_addr[w] != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_CLEAR: if (cnt == LAST) state_nxt = RF_IDLE;
                else             cnt_nxt   = cnt + AW'(1);
      RF_IDLE:  if (init_req) begin
                  state_nxt = RF_CLEAR;
                  cnt_nxt   = AW'(1);
                end
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RF_CLEAR;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  // storage has no reset; the sweep is what makes it clean
  always_ff @(posedge clk)
    if (state == RF_CLEAR) regs[cnt] <= '0;
    else
      for (int w = 0; w < NWP; w++)
        if (wr_ok[w]) regs[wr_addr[w]] <= wr_data[w];

  rf_scoreboard #(.NREG(NREG), .NRP(NRP), .NWP(NWP)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (idle && init_req),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .set_en   (idle && sb_set_en),
    .set_addr (sb_set_addr),
    .lk_addr  (rd_addr),
    .busy     (busy_raw)
  );

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rd_data[i] = '0;
      sb_busy[i] = 1'b0;
      if (idle && rd_addr[i] != '0) begin
        rd_data[i] = regs[rd_addr[i]];
        sb_busy[i] = busy_raw[i];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWP; w++)
          if (wr_ok[w] && wr_addr[w] == rd_addr[i]) begin
            rd_data[i] = wr_data[w];
            sb_busy[i] = 1'b0;
          end
`endif
      end
    end
  end
endmodule

// File: tb/tb_rf_mp.sv
// Randomized + directed bench for rf_mp against a behavioural register-file model.
module tb_rf_mp;
  localparam int DW = 32, NREG = 32, NRP = 2, NWP = 2, AW = 5;

  logic                   clk = 1'b0, rst_n = 1'b0, init_req = 1'b0;
  logic                   ready;
  logic [NWP-1:0]         wr_en = '0;
  logic [NWP-1:0][AW-1:0] wr_addr = '0;
  logic [NWP-1:0][DW-1:0] wr_data = '0;
  logic [NRP-1:0][AW-1:0] rd_addr = '0;
  logic [NRP-1:0][DW-1:0] rd_data;
  logic                   sb_set_en = 1'b0;
  logic [AW-1:0]          sb_set_addr = '0;
  logic [NRP-1:0]         sb_busy;

  rf_mp #(.DW(DW), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model: ready flag, sweep cycles remaining, register values, pending flags
  bit          m_ready;
  int          m_left;
  logic [DW-1:0] m_regs [NREG];
  bit          m_pend [NREG];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_ready = 0;
    m_left  = NREG - 1;
    foreach (m_pend[r]) m_pend[r] = 0;
  endtask

  task automatic m_clock();
    if (!rst_n) m_reset();
    else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        foreach (m_regs[r]) m_regs[r] = '0;
      end
    end else begin
      for (int w = 0; w < NWP; w++)
        if (wr_en[w] && wr_addr[w] != 0) begin
          m_regs[wr_addr[w]] = wr_data[w];
          m_pend[wr_addr[w]] = 0;
        end
      if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_addr] = 1;
      if (init_req) m_reset();
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(int i);
    logic [DW-1:0] v = '0;
    if (m_ready && rd_addr[i] != 0) begin
      v = m_regs[rd_addr[i]];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NWP; w++)
        if (wr_en[w] && wr_addr[w] == rd_addr[i]) v = wr_data[w];
`endif
    end
    return v;
  endfunction

  function automatic logic exp_busy(int i);
    logic b = 1'b0;
    if (m_ready && rd_addr[i] != 0) begin
      b = m_pend[rd_addr[i]];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NWP; w++)
        if (wr_en[w] && wr_addr[w] == rd_addr[i]) b = 1'b0;
`endif
    end
    return b;
  endfunction

  // compare all outputs against the model, then take one clock edge
  task automatic step();
    #1;
    chk("ready", ready, m_ready);
    for (int i = 0; i < NRP; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i], exp_rd(i));
      chk($sformatf("sb_busy%0d", i), sb_busy[i], exp_busy(i));
    end
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en = '0; sb_set_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic rnd_in(input int init_odds);
    for (int w = 0; w < NWP; w++) begin
      wr_en[w]   = 1'($urandom_range(0, 1));
      wr_addr[w] = AW'($urandom_range(0, 7));
      wr_data[w] = $urandom;
    end
    for (int i = 0; i < NRP; i++) rd_addr[i] = AW'($urandom_range(0, 7));
    sb_set_en   = 1'($urandom_range(0, 1));
    sb_set_addr = AW'($urandom_range(0, 7));
    init_req    = (init_odds > 0) && ($urandom_range(0, init_odds - 1) == 0);
  endtask

  task automatic sweep_len(input string tag);
    int n = 0;
    while (!ready && n < 100) begin step(); n++; end
    chk(tag, n, NREG - 1);
  endtask

  initial begin
    foreach (m_regs[r]) m_regs[r] = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #1 chk("reset_ready", ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // sweep with noise on the write/set/init inputs
    for (int c = 0; c < NREG - 1; c++) begin
      rnd_in(4);
      for (int w = 0; w < NWP; w++) wr_addr[w] = AW'($urandom_range(1, NREG - 1));
      chk("sweep_ready", ready, 0);
      step();
    end
    quiet();
    #1 chk("ready_after_sweep", ready, 1);
    for (int r = 0; r < NREG; r++) begin
      rd_addr[0] = AW'(r);
      #1 chk($sformatf("clean_x%0d", r), rd_data[0], 0);
    end

    // write x5, read same cycle and next
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5;
`ifdef RF_BYPASS_EN
    #1 chk("x5_same_cycle", rd_data[0], 32'hDEADBEEF);
`else
    #1 chk("x5_same_cycle", rd_data[0], 0);
`endif
    step(); quiet();
    #1 chk("x5_next_cycle", rd_data[0], 32'hDEADBEEF);

    // two ports to x9: port1 wins
    wr_en = 2'b11; wr_addr[0] = 9; wr_data[0] = 1; wr_addr[1] = 9; wr_data[1] = 2;
    step(); quiet(); rd_addr[0] = 9;
    #1 chk("x9_priority", rd_data[0], 2);

    // x0 is immune to writes and sb_set
    wr_en = 2'b01; wr_addr[0] = 0; wr_data[0] = 32'hFFFFFFFF;
    sb_set_en = 1'b1; sb_set_addr = 0; rd_addr[0] = 0;
    step(); quiet();
    #1 chk("x0_data", rd_data[0], 0);
    chk("x0_busy", sb_busy[0], 0);

    // scoreboard on x7
    rd_addr[1] = 7;
    sb_set_en = 1'b1; sb_set_addr = 7;
    step(); quiet();
    #1 chk("x7_set", sb_busy[1], 1);
    wr_en = 2'b10; wr_addr[1] = 7; wr_data[1] = 32'h77;
    step(); quiet();
    #1 chk("x7_clear", sb_busy[1], 0);
    wr_en = 2'b01; wr_addr[0] = 7; wr_data[0] = 32'h78; sb_set_en = 1'b1; sb_set_addr = 7;
    step(); quiet();
    #1 chk("x7_set_wins", sb_busy[1], 1);

    // init_req clears data and pending flags
    wr_en = 2'b01; wr_addr[0] = 3; wr_data[0] = 32'h55;
    step(); quiet();
    sb_set_en = 1'b1; sb_set_addr = 3;
    step(); quiet(); rd_addr[0] = 3;
    #1 chk("x3_loaded", rd_data[0], 32'h55);
    chk("x3_pending", sb_busy[0], 1);
    init_req = 1'b1;
    step(); quiet();
    #1 chk("init_ready_drop", ready, 0);
    sweep_len("init_sweep_len");
    #1 chk("x3_cleared", rd_data[0], 0);
    chk("x3_not_pending", sb_busy[0], 0);

    // reset in the middle of a sweep restarts the count
    init_req = 1'b1;
    step(); quiet();
    repeat (10) step();
    rst_n = 1'b0; m_reset();
    step();
    rst_n = 1'b1;
    sweep_len("restart_sweep_len");

    // randomized traffic including occasional re-init
    for (int c = 0; c < 400; c++) begin
      rnd_in(40);
      step();
    end
    quiet();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
